// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave responder backed by a word-addressed register-array SRAM.
// Independent write (AW/W/B) and read (AR/R) FSMs share one memory array, so a read
// burst and a write burst can be in flight together. IDs are echoed unchanged on B/R.
// Optional build macro: AXI4_SRAM_ERR_CHECK_EN adds range/size/burst checks that
// return SLVERR on B and zero data/strobes on R for faulting beats.
// Handshake rule used on every channel: a transfer happens on a rising ACLK edge where
// VALID and READY are both high; VALID and payload hold until then, and READY never
// looks at VALID (all READY/VALID outputs decode directly from FSM state registers).
module axi4_sram_slave #(
  parameter int                    ID_WIDTH   = 6,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // write address
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [1:0]              AWLOCK,
  input  logic [3:0]              AWCACHE,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [1:0]              ARLOCK,
  input  logic [3:0]              ARCACHE,
  input  logic [2:0]              ARPORT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [DATA_WIDTH/8-1:0] RSTRB,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  // FSM state visibility
  output logic [1:0]              dbg_wr_state_o,
  output logic [1:0]              dbg_rd_state_o
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int WORD_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  // *_INIT holds READY low through reset; READY rises one edge after release
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA}         rd_state_e;

  // next beat address: FIXED holds, WRAP stays in the aligned (LEN+1)*2^SIZE window,
  // INCR (and the reserved 2'b11 encoding) steps by 2^SIZE
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask, inc;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    inc  = a + step;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  // memory word selected by a byte address (wraps modulo MEM_DEPTH)
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> WORD_SHIFT);
  endfunction

  // byte lanes [offset, offset + 2^SIZE) inside the aligned word
  function automatic logic [STRB_W-1:0] lane_mask(input logic [WORD_SHIFT-1:0] lo,
                                                  input logic [2:0] size);
    int off, nb;
    off = int'(lo);
    nb  = 1 << size;
    for (int i = 0; i < STRB_W; i++) lane_mask[i] = (i >= off) && (i < off + nb);
  endfunction

`ifdef AXI4_SRAM_ERR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

  // beat faults: outside the SRAM window, reserved burst type, or beat wider than bus
  function automatic logic beat_fault(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [2:0] size,
                                      input logic [1:0] burst);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return off[ADDR_WIDTH] || (off >= SPAN) || (burst == 2'b11) || (int'(size) > WORD_SHIFT);
  endfunction
`endif

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic [2:0]            wr_size_q, wr_size_d;
  logic [1:0]            wr_burst_q, wr_burst_d;
  logic                  wr_err_q, wr_err_d;
  logic [STRB_W-1:0]     mem_we;
  logic [IDX_W-1:0]      mem_widx;

  rd_state_e             rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, ld_addr;
  logic [7:0]            rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [2:0]            rd_size_q, rd_size_d, ld_size;
  logic [1:0]            rd_burst_q, rd_burst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [STRB_W-1:0]     rstrb_q, rstrb_d;
  logic                  rlast_q, rlast_d, ld_en;
`ifdef AXI4_SRAM_ERR_CHECK_EN
  logic                  rd_err_q, rd_err_d;
`endif

  // protection/cache/lock attributes carry no meaning for an SRAM
  logic unused_attr;
  assign unused_attr = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPORT};

  // write FSM next state: capture AW, store W beats, then hold B until accepted
  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    mem_we     = '0;
    mem_widx   = word_idx(wr_addr_q);
    unique case (wr_state_q)
      W_INIT: wr_state_d = W_IDLE;
      W_IDLE: if (AWVALID) begin
        wr_id_d    = AWID;
        wr_addr_d  = AWADDR;
        wr_len_d   = AWLEN;
        wr_size_d  = AWSIZE;
        wr_burst_d = AWBURST;
        wr_cnt_d   = '0;
        wr_err_d   = 1'b0;
        wr_state_d = W_DATA;
      end
      W_DATA: if (WVALID) begin
        mem_we = WSTRB;
`ifdef AXI4_SRAM_ERR_CHECK_EN
        if (beat_fault(wr_addr_q, wr_size_q, wr_burst_q)) begin
          mem_we   = '0;
          wr_err_d = 1'b1;
        end
`endif
        // length comes from AWLEN; a misplaced WLAST only flags the response
        if (WLAST != (wr_cnt_q == wr_len_q)) wr_err_d = 1'b1;
        if (wr_cnt_q == wr_len_q) begin
          wr_state_d = W_RESP;
        end else begin
          wr_cnt_d  = wr_cnt_q + 8'd1;
          wr_addr_d = next_addr(wr_addr_q, wr_len_q, wr_size_q, wr_burst_q);
        end
      end
      W_RESP: if (BREADY) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // write FSM registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= W_INIT;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // byte-lane memory write; contents survive reset
  always_ff @(posedge ACLK) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (mem_we[i]) mem_q[mem_widx][8*i +: 8] <= WDATA[8*i +: 8];
    end
  end

  // read FSM next state: each AR or R handshake loads the next beat into the R registers;
  // the memory is sampled before this edge's write lands, so same-word reads see old data
  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    rd_cnt_d   = rd_cnt_q;
    rdata_d    = rdata_q;
    rstrb_d    = rstrb_q;
    rlast_d    = rlast_q;
    ld_en      = 1'b0;
    ld_addr    = rd_addr_q;
    ld_size    = rd_size_q;
`ifdef AXI4_SRAM_ERR_CHECK_EN
    rd_err_d   = rd_err_q;
`endif
    unique case (rd_state_q)
      R_INIT: rd_state_d = R_IDLE;
      R_IDLE: if (ARVALID) begin
        rd_id_d    = ARID;
        rd_addr_d  = ARADDR;
        rd_len_d   = ARLEN;
        rd_size_d  = ARSIZE;
        rd_burst_d = ARBURST;
        rd_cnt_d   = '0;
        rlast_d    = (ARLEN == 8'd0);
        ld_en      = 1'b1;
        ld_addr    = ARADDR;
        ld_size    = ARSIZE;
`ifdef AXI4_SRAM_ERR_CHECK_EN
        rd_err_d   = beat_fault(ARADDR, ARSIZE, ARBURST);
`endif
        rd_state_d = R_DATA;
      end
      R_DATA: if (RREADY) begin
        if (rd_cnt_q == rd_len_q) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_addr_d = next_addr(rd_addr_q, rd_len_q, rd_size_q, rd_burst_q);
          rd_cnt_d  = rd_cnt_q + 8'd1;
          rlast_d   = ((rd_cnt_q + 8'd1) == rd_len_q);
          ld_en     = 1'b1;
          ld_addr   = rd_addr_d;
`ifdef AXI4_SRAM_ERR_CHECK_EN
          rd_err_d  = rd_err_q | beat_fault(rd_addr_d, rd_size_q, rd_burst_q);
`endif
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (ld_en) begin
      rdata_d = mem_q[word_idx(ld_addr)];
      rstrb_d = lane_mask(ld_addr[WORD_SHIFT-1:0], ld_size);
`ifdef AXI4_SRAM_ERR_CHECK_EN
      if (rd_err_d) begin
        rdata_d = '0;
        rstrb_d = '0;
      end
`endif
    end
  end

  // read FSM registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= R_INIT;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_cnt_q   <= '0;
      rdata_q    <= '0;
      rstrb_q    <= '0;
      rlast_q    <= 1'b0;
`ifdef AXI4_SRAM_ERR_CHECK_EN
      rd_err_q   <= 1'b0;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_cnt_q   <= rd_cnt_d;
      rdata_q    <= rdata_d;
      rstrb_q    <= rstrb_d;
      rlast_q    <= rlast_d;
`ifdef AXI4_SRAM_ERR_CHECK_EN
      rd_err_q   <= rd_err_d;
`endif
    end
  end

  assign AWREADY        = (wr_state_q == W_IDLE);
  assign WREADY         = (wr_state_q == W_DATA);
  assign BVALID         = (wr_state_q == W_RESP);
  assign BID            = wr_id_q;
  assign BRESP          = {wr_err_q, 1'b0};
  assign ARREADY        = (rd_state_q == R_IDLE);
  assign RVALID         = (rd_state_q == R_DATA);
  assign RID            = rd_id_q;
  assign RDATA          = rdata_q;
  assign RSTRB          = rstrb_q;
  assign RLAST          = rlast_q;
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: directed bench for axi4_sram_slave (default 64-bit configuration).
// Inputs are driven and outputs sampled on the falling edge of ACLK.
module tb_axi4_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [5:0]  AWID = '0, BID, ARID = '0, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0, AWPROT = '0, ARPORT = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0, AWLOCK = '0, ARLOCK = '0, BRESP;
  logic [3:0]  AWCACHE = '0, ARCACHE = '0;
  logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic        BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY;
  logic        RLAST, RVALID, RREADY = 1'b0;
  logic [63:0] WDATA = '0, RDATA;
  logic [7:0]  WSTRB = '0, RSTRB;
  logic [1:0]  dbg_wr_state_o, dbg_rd_state_o;

  int checks = 0;
  int errors = 0;
  localparam int LIMIT = 100;

  logic [63:0] wbuf [16];
  logic [63:0] rexp [16];
  logic [7:0]  sexp [16];

  axi4_sram_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RSTRB(RSTRB), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .dbg_wr_state_o(dbg_wr_state_o), .dbg_rd_state_o(dbg_rd_state_o)
  );

  // clock
  always #5 ACLK = ~ACLK;

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one write burst of SIZE=3 beats from wbuf; WLAST driven on beat last_at
  task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input int last_at,
                          input logic [1:0] exp_resp);
    int t;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd3; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < LIMIT) begin @(negedge ACLK); t++; end
    chk("aw_wait", 64'(t < LIMIT), 64'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wbuf[b]; WSTRB = strb; WLAST = (b == last_at); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < LIMIT) begin @(negedge ACLK); t++; end
      chk("w_wait", 64'(t < LIMIT), 64'd1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid_after_last", 64'(BVALID), 64'd1);
    chk("bid", 64'(BID), 64'(id));
    chk("bresp", 64'(BRESP), 64'(exp_resp));
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_drop", 64'(BVALID), 64'd0);
    chk("awready_back", 64'(AWREADY), 64'd1);
  endtask

  // one read burst checked against rexp/sexp; stall inserts an RREADY-low cycle on even beats
  task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic stall);
    int t;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < LIMIT) begin @(negedge ACLK); t++; end
    chk("ar_wait", 64'(t < LIMIT), 64'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("rvalid_latency", 64'(RVALID), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!RVALID && t < LIMIT) begin @(negedge ACLK); t++; end
      chk("r_wait", 64'(t < LIMIT), 64'd1);
      chk($sformatf("rdata[%0d]", b), RDATA, rexp[b]);
      chk($sformatf("rstrb[%0d]", b), 64'(RSTRB), 64'(sexp[b]));
      chk($sformatf("rlast[%0d]", b), 64'(RLAST), 64'(b == int'(len)));
      chk($sformatf("rid[%0d]", b), 64'(RID), 64'(id));
      if (stall && (b % 2 == 0)) begin
        RREADY = 1'b0;
        @(negedge ACLK);
        chk($sformatf("rvalid_stall[%0d]", b), 64'(RVALID), 64'd1);
        chk($sformatf("rdata_stall[%0d]", b), RDATA, rexp[b]);
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    chk("rvalid_end", 64'(RVALID), 64'd0);
    chk("arready_end", 64'(ARREADY), 64'd1);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge ACLK);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_bid_bresp", 64'({BID, BRESP}), 64'd0);
    chk("rst_rid", 64'(RID), 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    chk("rst_rstrb", 64'(RSTRB), 64'd0);
    chk("rst_dbg_wr", 64'(dbg_wr_state_o), 64'd0);
    ARESETn = 1'b1;
    #1;
    chk("awready_before_edge", 64'(AWREADY), 64'd0);
    @(negedge ACLK);
    chk("awready_after_edge", 64'(AWREADY), 64'd1);
    chk("arready_after_edge", 64'(ARREADY), 64'd1);

    // INCR write 0x11..0x44 at 0x10, read back
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    do_write(6'h2A, 32'h10, 8'd3, 2'b01, 8'hFF, 3, 2'b00);
    rexp[0] = 64'h11; rexp[1] = 64'h22; rexp[2] = 64'h33; rexp[3] = 64'h44;
    for (int i = 0; i < 4; i++) sexp[i] = 8'hFF;
    do_read(6'h15, 32'h10, 8'd3, 3'd3, 2'b01, 1'b0);

    // fill words 0x00/0x08, then WRAP read from 0x18: 0x18,0x00,0x08,0x10
    wbuf[0] = 64'hA0; wbuf[1] = 64'hB0;
    do_write(6'h01, 32'h0, 8'd1, 2'b01, 8'hFF, 1, 2'b00);
    rexp[0] = 64'h22; rexp[1] = 64'hA0; rexp[2] = 64'hB0; rexp[3] = 64'h11;
    do_read(6'h33, 32'h18, 8'd3, 3'd3, 2'b10, 1'b0);

    // FIXED read repeats one word
    rexp[0] = 64'h11; rexp[1] = 64'h11; rexp[2] = 64'h11;
    do_read(6'h02, 32'h10, 8'd2, 3'd3, 2'b00, 1'b0);

    // partial strobe: low four bytes cleared
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(6'h03, 32'h100, 8'd0, 2'b01, 8'hFF, 0, 2'b00);
    wbuf[0] = 64'h0;
    do_write(6'h04, 32'h100, 8'd0, 2'b01, 8'h0F, 0, 2'b00);
    rexp[0] = 64'hFFFF_FFFF_0000_0000; sexp[0] = 8'hFF;
    do_read(6'h05, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0);

    // narrow 4-byte read at 0x104 covers upper lanes
    rexp[0] = 64'hFFFF_FFFF_0000_0000; sexp[0] = 8'hF0;
    do_read(6'h06, 32'h104, 8'd0, 3'd2, 2'b01, 1'b0);

    // early WLAST on beat 2 of 4: all four beats taken, SLVERR
    wbuf[0] = 64'h1; wbuf[1] = 64'h2; wbuf[2] = 64'h3; wbuf[3] = 64'h4;
    do_write(6'h3F, 32'h200, 8'd3, 2'b01, 8'hFF, 1, 2'b10);
    // missing WLAST on final beat also flags SLVERR
    do_write(6'h08, 32'h240, 8'd1, 2'b01, 8'hFF, 5, 2'b10);
    rexp[0] = 64'h1; rexp[1] = 64'h2; rexp[2] = 64'h3; rexp[3] = 64'h4;
    for (int i = 0; i < 4; i++) sexp[i] = 8'hFF;
    do_read(6'h09, 32'h200, 8'd3, 3'd3, 2'b01, 1'b0);

    // LEN=7 burst with RREADY toggling
    for (int k = 0; k < 8; k++) begin
      wbuf[k] = {8{8'(8'h50 + k)}};
      rexp[k] = {8{8'(8'h50 + k)}};
      sexp[k] = 8'hFF;
    end
    do_write(6'h0A, 32'h300, 8'd7, 2'b01, 8'hFF, 7, 2'b00);
    do_read(6'h0B, 32'h300, 8'd7, 3'd3, 2'b01, 1'b1);

`ifdef AXI4_SRAM_ERR_CHECK_EN
    // one past the window: SLVERR and the aliased word 0 untouched
    wbuf[0] = 64'hDEAD_BEEF;
    do_write(6'h0C, 32'h2000, 8'd0, 2'b01, 8'hFF, 0, 2'b10);
    rexp[0] = 64'hA0; sexp[0] = 8'hFF;
    do_read(6'h0D, 32'h0, 8'd0, 3'd3, 2'b01, 1'b0);
`endif

    // reset pulse while beat 2 of a read is presented
    ARID = 6'h07; ARADDR = 32'h300; ARLEN = 8'd7; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    RREADY = 1'b0;
    chk("midrst_beat2", RDATA, 64'h5252_5252_5252_5252);
    ARESETn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(RVALID), 64'd0);
    chk("midrst_arready", 64'(ARREADY), 64'd0);
    chk("midrst_rdata", RDATA, 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    chk("midrst_arready_hold", 64'(ARREADY), 64'd0);
    @(negedge ACLK);
    chk("midrst_arready_rise", 64'(ARREADY), 64'd1);
    do_read(6'h0E, 32'h300, 8'd7, 3'd3, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
